// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;  // 50 MHz / 9600 baud

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is dropped even if a pop coincides.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered 8N1 frames, LSB first, internal baud counter.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          UART_TX,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       pop_c;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       baud_last;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (sysclk),
    .rst         (reset),
    .push_i      (tx_valid),
    .push_data_i (tx_data),
    .pop_i       (pop_c),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign UART_TX   = tx_q;
  assign tx_busy   = busy_q;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != ST_IDLE) baud_d = baud_last ? '0 : baud_q + BW'(1);

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) pop_c = 1'b1;
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          if (!fifo_empty) pop_c   = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start shared by IDLE and back-to-back STOP exits.
    if (pop_c) begin
      state_d  = ST_START;
      baud_d   = '0;
      idx_d    = '0;
      shift_d  = fifo_head;
      tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_head;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_tx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          sysclk   = 1'b0;
  logic          reset    = 1'b1;
  logic [7:0]    tx_data  = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          UART_TX;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .UART_TX    (UART_TX),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // seq holds the line levels with the first transmitted bit at index nbits-1.
  task automatic check_frame(input string tag, input logic [10:0] seq, input int nbits, input int skip);
    for (int t = skip; t < nbits * int'(CPB); t++) begin
      check(tag, 32'({UART_TX, tx_busy}), 32'({seq[nbits - 1 - t / int'(CPB)], 1'b1}));
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    check("rst_line",  32'(UART_TX),    32'(1));
    check("rst_busy",  32'(tx_busy),    32'(0));
    check("rst_ready", 32'(tx_ready),   32'(1));
    check("rst_count", 32'(fifo_count), 32'(0));
    reset = 1'b0;
    step();

    for (int i = 0; i < 1000; i++) begin
      check("idle", 32'({UART_TX, tx_busy, tx_ready}), 32'(3'b101));
      step();
    end

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    check("p07_cnt", 32'(fifo_count), 32'(1));
    step();
    check_frame("p07_frame", 11'b01110000011, 11, 0);
    check("p07_end", 32'({UART_TX, tx_busy}), 32'(2'b10));

    tx_data = 8'h35; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    step();
    check_frame("p35_frame", 11'b01010110001, 11, 0);
    check("p35_end", 32'({UART_TX, tx_busy}), 32'(2'b10));
`else
    // Single frame 0x35
    tx_data = 8'h35; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    check("f35_cnt1", 32'(fifo_count), 32'(1));
    check("f35_pre",  32'({UART_TX, tx_busy}), 32'(2'b10));
    step();
    check("f35_cnt0", 32'(fifo_count), 32'(0));
    check_frame("f35_frame", 11'b00101011001, 10, 0);
    check("f35_end", 32'({UART_TX, tx_busy}), 32'(2'b10));

    // Back-to-back 0xA5, 0x5A
    tx_data = 8'hA5; tx_valid = 1'b1; step();
    check("b2b_cnt_a", 32'(fifo_count), 32'(1));
    tx_data = 8'h5A; step(); tx_valid = 1'b0;
    check("b2b_cnt_b", 32'(fifo_count), 32'(1));
    check_frame("b2b_a5", 11'b00101001011, 10, 0);
    check_frame("b2b_5a", 11'b00010110101, 10, 0);
    check("b2b_end", 32'({UART_TX, tx_busy}), 32'(2'b10));

    // Fill until full; 0x06 must be dropped
    tx_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tx_data = 8'(i);
      step();
      if (i == 5) begin
        check("fill_cnt5",   32'(fifo_count), 32'(4));
        check("fill_ready5", 32'(tx_ready),   32'(0));
      end
    end
    tx_valid = 1'b0;
    check("fill_cnt6",   32'(fifo_count), 32'(4));
    check("fill_ready6", 32'(tx_ready),   32'(0));
    check_frame("fill_01", 11'b00100000001, 10, 4);
    check("fill_cnt_after01", 32'(fifo_count), 32'(3));
    check("fill_ready_after01", 32'(tx_ready), 32'(1));
    check_frame("fill_02", 11'b00010000001, 10, 0);
    check_frame("fill_03", 11'b00110000001, 10, 0);
    check_frame("fill_04", 11'b00001000001, 10, 0);
    check_frame("fill_05", 11'b00101000001, 10, 0);
    check("fill_end", 32'({UART_TX, tx_busy, fifo_count}), 32'({1'b1, 1'b0, CW'(0)}));
    for (int i = 0; i < 200; i++) begin
      check("fill_no06", 32'({UART_TX, tx_busy}), 32'(2'b10));
      step();
    end

    // Reset in the middle of data bit 3 of 0xFF with two bytes queued
    tx_data = 8'hFF; tx_valid = 1'b1; step();
    tx_data = 8'h11; step();
    tx_data = 8'h22; step(); tx_valid = 1'b0;
    check("mid_cnt2", 32'(fifo_count), 32'(2));
    repeat (71) step();
    check("mid_bit3", 32'({UART_TX, tx_busy}), 32'(2'b11));
    reset = 1'b1;
    #1;
    check("mid_rst_line",  32'(UART_TX),    32'(1));
    check("mid_rst_busy",  32'(tx_busy),    32'(0));
    check("mid_rst_count", 32'(fifo_count), 32'(0));
    check("mid_rst_ready", 32'(tx_ready),   32'(1));
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      check("mid_quiet", 32'({UART_TX, tx_busy, fifo_count}), 32'({1'b1, 1'b0, CW'(0)}));
      step();
    end
    tx_data = 8'h35; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    step();
    check_frame("mid_recover", 11'b00101011001, 10, 0);
    check("mid_recover_end", 32'({UART_TX, tx_busy}), 32'(2'b10));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and shifts them out on `UART_TX` as 8N1 frames, LSB first. It is the transmit counterpart of the CPU's UART receive path. It generates its own bit timing from `sysclk` with an internal baud counter, so no external baud clock is needed, and it sits between the CPU's memory-mapped UART register and the `UART_TX` pin.

## Interface
- `CLKS_PER_BIT`, default 5208: sysclk cycles per serial bit (50 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; power of two, ≥ 2.
- `sysclk` in 1: system clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO not full; a byte is accepted when `tx_valid && tx_ready` at a rising edge.
- `UART_TX` out 1: serial line, idle high, registered output.
- `tx_busy` out 1: a frame is in progress (FSM not IDLE).
- `fifo_count` out $clog2(FIFO_DEPTH)+1: entries currently queued, excluding the byte being shifted.

## Operation
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE → START when the FIFO is non-empty. The head entry is popped into the shift register on the same edge, the baud counter is cleared, and `UART_TX` is set to 0.
- START → DATA after CLKS_PER_BIT cycles. `UART_TX` = shift[0].
- DATA shifts right every CLKS_PER_BIT cycles. A 3-bit index counts 0..7; after bit 7 the FSM goes to STOP (or PARITY) and `UART_TX` = 1 (or the parity bit).
- STOP lasts exactly CLKS_PER_BIT cycles. On its last cycle:
  - FIFO non-empty → go straight to START with a pop and `UART_TX` = 0. There is no extra idle bit between frames.
  - FIFO empty → go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- FIFO push and pop on the same edge: count is unchanged and data order is preserved.
- A push while full is ignored (`tx_ready` = 0). There is no bypass around a full FIFO.
- `tx_data` and `tx_valid` are don't-care while `tx_ready` = 0.
- Reset values: `UART_TX` = 1, `tx_busy` = 0, `tx_ready` = 1, `fifo_count` = 0, FSM = IDLE, all counters 0.
- Reset mid-frame: the line goes high immediately (asynchronous), the frame is truncated and the FIFO is flushed. After reset release there is no partial resend.

## Timing
- Byte accepted at edge N into an empty FIFO with the FSM in IDLE:
  - edge N+1: pop, `UART_TX` falls, `tx_busy` rises.
  - `fifo_count` reads 1 after edge N and 0 after edge N+1.
- Frame length: 10·CLKS_PER_BIT cycles (11· with parity), measured from the `UART_TX` fall to the end of the stop bit.
- Back-to-back frames: the next start bit begins exactly one frame length after the previous one.
- `tx_busy` falls on the edge where STOP exits to IDLE.
- `tx_ready` = (`fifo_count` < FIFO_DEPTH). It is combinational from registered state.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP and carries the even parity bit, the XOR of the 8 data bits.
  - Frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and frames are 8N1.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3-bit.
  - Default CLKS_PER_BIT for 50 MHz/9600.
- Sub-module `uart_tx_fifo`: synchronous FIFO, DEPTH parameter, push/pop/full/empty/count, asynchronous active-high reset. The receive side can reuse it.
- Top `uart_tx` holds the FSM, baud counter, bit index, shift register and the output register.

## Test plan
- CLKS_PER_BIT=16; push 0x35 → `UART_TX` holds 0,1,0,1,0,1,1,0,0,1, each level for 16 cycles; frame is 160 cycles; `tx_busy` falls 160 cycles after the start fall.
- Push 0xA5 then 0x5A on consecutive cycles → the second start bit falls exactly 160 cycles after the first; line reads 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1.
- Hold `tx_valid` with 0x01..0x06 on six consecutive edges → 0x01 is shifting; `fifo_count` reaches 4 and `tx_ready` = 0 after the 5th edge; 0x06 is not accepted; 0x01..0x05 are transmitted in order.
- Assert `reset` for 2 cycles in the middle of the DATA bit 3 of 0xFF while 2 bytes are queued → `UART_TX` = 1 immediately; `fifo_count` = 0; nothing is transmitted after release until a new push.
- With `UART_TX_PARITY_EN`: push 0x07 → parity bit 1; push 0x35 → parity bit 0; frame is 176 cycles.
- Idle check: no push for 1000 cycles after reset → `UART_TX` stays 1, `tx_busy` stays 0, `tx_ready` stays 1.
